// File: rtl/etherneco_synctimer_pkg.sv
// Shared definitions for the EtherNeCo sync-timer slave channel:
// command FSM state encoding, default command codes and the byte layout
// of the sync command payload.
package etherneco_synctimer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } cmd_state_t;

    localparam logic [7:0] CMD_ADJUST_DEFAULT = 8'h01;
    localparam logic [7:0] CMD_SET_DEFAULT    = 8'h03;

    // Command payload layout: code, master time (LE), offset (LE), ignored tail.
    localparam int CODE_POS = 0;

    function automatic int time_pos();
        return CODE_POS + 1;
    endfunction

    function automatic int offset_pos(input int time_bytes);
        return time_pos() + time_bytes;
    endfunction

    function automatic int need_bytes(input int time_bytes, input int offset_bytes);
        return offset_pos(time_bytes) + offset_bytes;
    endfunction

endpackage

// File: rtl/etherneco_elapsed_filter.sv
// Round-trip sample computation and optional exponential smoothing.
// The sample is the modular difference between the response-start time and
// the latched command-end time. With AVG_SHIFT = 0 the raw sample is held;
// otherwise the first sample after reset loads directly and later samples
// move the estimate by (sample - estimate) >>> AVG_SHIFT.
module etherneco_elapsed_filter #(
    parameter int ELAPSED_WIDTH = 32,
    parameter int AVG_SHIFT     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ELAPSED_WIDTH-1:0] now_low,
    input  logic [ELAPSED_WIDTH-1:0] start_low,
    input  logic                     sample_valid,
    output logic [ELAPSED_WIDTH-1:0] elapsed_time
);

    logic [ELAPSED_WIDTH-1:0] sample;
    logic signed [ELAPSED_WIDTH:0] diff;
    logic [ELAPSED_WIDTH-1:0] ema_next;
    logic loaded_q;

    assign sample   = now_low - start_low;
    assign diff     = $signed({1'b0, sample}) - $signed({1'b0, elapsed_time});
    assign ema_next = elapsed_time + ELAPSED_WIDTH'(diff >>> AVG_SHIFT);

    // Load the first sample directly, then either track raw or smooth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elapsed_time <= '0;
            loaded_q     <= 1'b0;
        end else if (sample_valid) begin
            loaded_q <= 1'b1;
            if (AVG_SHIFT == 0 || !loaded_q) begin
                elapsed_time <= sample;
            end else begin
                elapsed_time <= ema_next;
            end
        end
    end

endmodule

// File: rtl/etherneco_synctimer_slave_ch.sv
// EtherNeCo sync-timer slave channel.
// Strobe semantics: every *_valid / *_start / *_end / *_error input is a
// single-cycle qualifier sampled on the rising clock edge; there is no
// back-pressure. correct_valid and m_res_valid are registered single-cycle
// strobes, and their data outputs are meaningful only while the strobe is
// high (m_res_data reads 0 otherwise; correct_* hold their last value).
module etherneco_synctimer_slave_ch
    import etherneco_synctimer_pkg::*;
#(
    parameter int         TIMER_WIDTH   = 64,
    parameter int         TIME_BYTES    = 8,
    parameter int         OFFSET_BYTES  = 2,
    parameter int         ELAPSED_BYTES = 4,
    parameter int         RES_BASE      = 9,
    parameter int         AVG_SHIFT     = 0,
    parameter logic [7:0] CMD_ADJUST    = CMD_ADJUST_DEFAULT,
    parameter logic [7:0] CMD_SET       = CMD_SET_DEFAULT,
    parameter int         STAT_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [TIMER_WIDTH-1:0]       current_time,
    input  logic                         cmd_rx_start,
    input  logic                         cmd_rx_end,
    input  logic                         cmd_rx_error,
    input  logic [7:0]                   cmd_rx_node,
    input  logic [15:0]                  s_cmd_pos,
    input  logic [7:0]                   s_cmd_data,
    input  logic                         s_cmd_valid,
    input  logic                         res_rx_start,
    input  logic                         res_rx_error,
    input  logic [15:0]                  s_res_pos,
    input  logic                         s_res_valid,
    output logic [7:0]                   m_res_data,
    output logic                         m_res_valid,
    output logic                         correct_override,
    output logic [TIMER_WIDTH-1:0]       correct_time,
    output logic                         correct_valid,
    output logic [8*ELAPSED_BYTES-1:0]   elapsed_time,
    output logic [STAT_WIDTH-1:0]        stat_correct_count,
    output logic [STAT_WIDTH-1:0]        stat_error_count,
    output cmd_state_t                   dbg_state
);

    localparam int          EW       = 8 * ELAPSED_BYTES;
    localparam int          TW8      = 8 * TIME_BYTES;
    localparam int          OW8      = 8 * OFFSET_BYTES;
    localparam int          TIME_LO  = time_pos();
    localparam int          OFF_LO   = offset_pos(TIME_BYTES);
    localparam logic [15:0] NEED     = 16'(need_bytes(TIME_BYTES, OFFSET_BYTES));

    cmd_state_t        state_q;
    logic [15:0]       cnt_q, cnt_n;
    logic [7:0]        code_q, code_n;
    logic [TW8-1:0]    time_q, time_n;
    logic [OW8-1:0]    off_q, off_n;
    logic [7:0]        node_q;

    logic              frame_end, frame_ok, frame_bad, code_known;
    logic [TIMER_WIDTH-1:0] sum_time;

    logic              armed_q, sample_fire;
    logic [EW-1:0]     start_q;

    logic [15:0]       slot, rel;
    logic              in_slot, insert_hit, suppress_q;
    logic [7:0]        slot_byte;

    assign dbg_state = state_q;

    // Next-value view of the capture registers so a byte arriving together
    // with cmd_rx_end still takes part in the frame decision.
    always_comb begin
        cnt_n  = cnt_q;
        code_n = code_q;
        time_n = time_q;
        off_n  = off_q;
        if (state_q == ST_RECV && s_cmd_valid) begin
            if (cnt_q != NEED) begin
                cnt_n = cnt_q + 16'd1;
            end
            if (s_cmd_pos == 16'(CODE_POS)) begin
                code_n = s_cmd_data;
            end
            for (int i = 0; i < TIME_BYTES; i++) begin
                if (s_cmd_pos == 16'(TIME_LO + i)) begin
                    time_n[i*8 +: 8] = s_cmd_data;
                end
            end
            for (int i = 0; i < OFFSET_BYTES; i++) begin
                if (s_cmd_pos == 16'(OFF_LO + i)) begin
                    off_n[i*8 +: 8] = s_cmd_data;
                end
            end
        end
    end

    assign code_known = (code_n == CMD_SET) || (code_n == CMD_ADJUST);
    assign frame_end  = (state_q == ST_RECV) && (cmd_rx_end || cmd_rx_error);
    assign frame_ok   = (state_q == ST_RECV) && cmd_rx_end && !cmd_rx_error &&
                        (cnt_n == NEED) && code_known;
    assign frame_bad  = frame_end && !frame_ok;
    assign sum_time   = TIMER_WIDTH'(time_n) + TIMER_WIDTH'(off_n);

    // Command FSM, field capture and registered correction request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            code_q           <= '0;
            time_q           <= '0;
            off_q            <= '0;
            node_q           <= '0;
            correct_valid    <= 1'b0;
            correct_override <= 1'b0;
            correct_time     <= '0;
        end else begin
            correct_valid <= 1'b0;
            if (cmd_rx_start) begin
                state_q <= ST_RECV;
                cnt_q   <= '0;
                code_q  <= '0;
                time_q  <= '0;
                off_q   <= '0;
                node_q  <= cmd_rx_node;
            end else if (frame_end) begin
                state_q <= ST_IDLE;
            end else if (state_q == ST_RECV) begin
                cnt_q  <= cnt_n;
                code_q <= code_n;
                time_q <= time_n;
                off_q  <= off_n;
            end
            if (frame_ok) begin
                correct_valid    <= 1'b1;
                correct_override <= (code_n == CMD_SET);
                correct_time     <= sum_time;
            end
        end
    end

    // Saturating frame statistics; one increment per terminated frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_correct_count <= '0;
            stat_error_count   <= '0;
        end else begin
            if (frame_ok && stat_correct_count != '1) begin
                stat_correct_count <= stat_correct_count + 1'b1;
            end
            if (frame_bad && stat_error_count != '1) begin
                stat_error_count <= stat_error_count + 1'b1;
            end
        end
    end

    assign sample_fire = res_rx_start && armed_q;

    // Round-trip arm: the old arm is consumed by res_rx_start before a
    // coincident accepted command end re-arms with a fresh start time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q <= 1'b0;
            start_q <= '0;
        end else if (frame_ok) begin
            armed_q <= 1'b1;
            start_q <= current_time[EW-1:0];
        end else if (sample_fire) begin
            armed_q <= 1'b0;
        end
    end

    generate
        if (TIMER_WIDTH > EW) begin : g_time_hi
            logic unused_time_hi;
            assign unused_time_hi = ^current_time[TIMER_WIDTH-1:EW];
        end
    endgenerate

    etherneco_elapsed_filter #(
        .ELAPSED_WIDTH (EW),
        .AVG_SHIFT     (AVG_SHIFT)
    ) u_filter (
        .clk          (clk),
        .reset        (reset),
        .now_low      (current_time[EW-1:0]),
        .start_low    (start_q),
        .sample_valid (sample_fire),
        .elapsed_time (elapsed_time)
    );

    // Slot arithmetic is 16-bit modular so large node indices wrap.
    assign slot    = 16'(RES_BASE) + 16'(node_q) * 16'(ELAPSED_BYTES);
    assign rel     = s_res_pos - slot;
    assign in_slot = rel < 16'(ELAPSED_BYTES);

    // Little-endian byte of elapsed_time selected by offset within the slot.
    always_comb begin
        slot_byte = '0;
        for (int i = 0; i < ELAPSED_BYTES; i++) begin
            if (rel == 16'(i)) begin
                slot_byte = elapsed_time[i*8 +: 8];
            end
        end
    end

    assign insert_hit = s_res_valid && in_slot && !suppress_q && !res_rx_error;

    // An errored response frame stops insertion until the next frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            suppress_q <= 1'b0;
        end else if (res_rx_error) begin
            suppress_q <= 1'b1;
        end else if (res_rx_start) begin
            suppress_q <= 1'b0;
        end
    end

    // Registered replacement byte for this node's response slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_res_valid <= 1'b0;
            m_res_data  <= '0;
        end else begin
            m_res_valid <= insert_hit;
            m_res_data  <= insert_hit ? slot_byte : 8'h00;
        end
    end

endmodule

// File: tb/tb_etherneco_synctimer_slave_ch.sv
// Bench for the sync-timer slave channel: default-parameter instance plus an
// AVG_SHIFT = 2 instance sharing the same stimulus for smoothing checks.
module tb_etherneco_synctimer_slave_ch;
    import etherneco_synctimer_pkg::*;

    localparam int NEED     = 11;
    localparam int RES_BASE = 9;
    localparam int EB       = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [63:0] current_time = 64'd0;
    logic        cmd_rx_start = 0, cmd_rx_end = 0, cmd_rx_error = 0;
    logic [7:0]  cmd_rx_node = 0;
    logic [15:0] s_cmd_pos = 0;
    logic [7:0]  s_cmd_data = 0;
    logic        s_cmd_valid = 0;
    logic        res_rx_start = 0, res_rx_error = 0;
    logic [15:0] s_res_pos = 0;
    logic        s_res_valid = 0;

    logic [7:0]  m_res_data;
    logic        m_res_valid, correct_override, correct_valid;
    logic [63:0] correct_time;
    logic [31:0] elapsed_time;
    logic [15:0] stat_correct_count, stat_error_count;
    cmd_state_t  dbg_state;

    logic [7:0]  e_res_data;
    logic        e_res_valid, e_override, e_valid;
    logic [63:0] e_time;
    logic [31:0] e_elapsed;
    logic [15:0] e_sc, e_se;
    cmd_state_t  e_state;

    etherneco_synctimer_slave_ch u_dut (
        .clk(clk), .reset(reset), .current_time(current_time),
        .cmd_rx_start(cmd_rx_start), .cmd_rx_end(cmd_rx_end), .cmd_rx_error(cmd_rx_error),
        .cmd_rx_node(cmd_rx_node), .s_cmd_pos(s_cmd_pos), .s_cmd_data(s_cmd_data),
        .s_cmd_valid(s_cmd_valid), .res_rx_start(res_rx_start), .res_rx_error(res_rx_error),
        .s_res_pos(s_res_pos), .s_res_valid(s_res_valid),
        .m_res_data(m_res_data), .m_res_valid(m_res_valid),
        .correct_override(correct_override), .correct_time(correct_time),
        .correct_valid(correct_valid), .elapsed_time(elapsed_time),
        .stat_correct_count(stat_correct_count), .stat_error_count(stat_error_count),
        .dbg_state(dbg_state)
    );

    etherneco_synctimer_slave_ch #(.AVG_SHIFT(2)) u_dut_ema (
        .clk(clk), .reset(reset), .current_time(current_time),
        .cmd_rx_start(cmd_rx_start), .cmd_rx_end(cmd_rx_end), .cmd_rx_error(cmd_rx_error),
        .cmd_rx_node(cmd_rx_node), .s_cmd_pos(s_cmd_pos), .s_cmd_data(s_cmd_data),
        .s_cmd_valid(s_cmd_valid), .res_rx_start(res_rx_start), .res_rx_error(res_rx_error),
        .s_res_pos(s_res_pos), .s_res_valid(s_res_valid),
        .m_res_data(e_res_data), .m_res_valid(e_res_valid),
        .correct_override(e_override), .correct_time(e_time),
        .correct_valid(e_valid), .elapsed_time(e_elapsed),
        .stat_correct_count(e_sc), .stat_error_count(e_se),
        .dbg_state(e_state)
    );

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] corr_q[$];
    logic [7:0]  res_q[$];

    logic [7:0]  fb [0:15];
    int          m_corr, m_err;
    bit          m_armed, m_loaded, m_supp;
    logic [31:0] m_start, m_raw, m_ema;
    int          m_node;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_corr = 0; m_err = 0; m_armed = 0; m_loaded = 0; m_supp = 0;
        m_start = 0; m_raw = 0; m_ema = 0; m_node = 0;
        corr_q.delete();
        res_q.delete();
    endtask

    task automatic model_res_start(input logic [63:0] t);
        logic [31:0] s;
        m_supp = 0;
        if (m_armed) begin
            s = t[31:0] - m_start;
            m_raw = s;
            if (!m_loaded) m_ema = s;
            else m_ema = 32'(longint'(m_ema) + ((longint'(s) - longint'(m_ema)) >>> 2));
            m_loaded = 1;
            m_armed = 0;
        end
    endtask

    task automatic model_cmd_end(input int nb, input bit err, input logic [63:0] t);
        logic [63:0] tm;
        logic [15:0] of;
        if (!err && nb >= NEED && (fb[0] == 8'h01 || fb[0] == 8'h03)) begin
            tm = 64'd0;
            for (int k = 0; k < 8; k++) tm = tm | (64'(fb[1+k]) << (8*k));
            of = {fb[10], fb[9]};
            corr_q.push_back({fb[0] == 8'h03, tm + 64'(of)});
            m_corr++;
            m_armed = 1;
            m_start = t[31:0];
        end else begin
            m_err++;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [64:0] ec;
        logic [7:0]  eb;
        if (reset) begin
            if (correct_valid) begin
                if (corr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL corr_unexpected actual=%h expected=none", correct_time);
                end else begin
                    ec = corr_q.pop_front();
                    check("corr_override", 64'(correct_override), 64'(ec[64]));
                    check("corr_time", correct_time, ec[63:0]);
                end
            end
            if (m_res_valid) begin
                if (res_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL res_unexpected actual=%h pos_expected=none", m_res_data);
                end else begin
                    eb = res_q.pop_front();
                    check("res_byte", 64'(m_res_data), 64'(eb));
                end
            end else begin
                check("res_data_idle", 64'(m_res_data), 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        current_time = current_time + 64'd1;
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        cmd_rx_start = 0; cmd_rx_end = 0; cmd_rx_error = 0; s_cmd_valid = 0;
        res_rx_start = 0; res_rx_error = 0; s_res_valid = 0;
        #1;
        check({tag, "_correct_valid"}, 64'(correct_valid), 64'd0);
        check({tag, "_override"}, 64'(correct_override), 64'd0);
        check({tag, "_correct_time"}, correct_time, 64'd0);
        check({tag, "_elapsed"}, 64'(elapsed_time), 64'd0);
        check({tag, "_elapsed_ema"}, 64'(e_elapsed), 64'd0);
        check({tag, "_m_res_valid"}, 64'(m_res_valid), 64'd0);
        check({tag, "_m_res_data"}, 64'(m_res_data), 64'd0);
        check({tag, "_stat_correct"}, 64'(stat_correct_count), 64'd0);
        check({tag, "_stat_error"}, 64'(stat_error_count), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic build_frame(input logic [7:0] code, input logic [63:0] tm, input logic [15:0] of);
        fb[0] = code;
        for (int k = 0; k < 8; k++) fb[1+k] = tm[8*k +: 8];
        fb[9]  = of[7:0];
        fb[10] = of[15:8];
        for (int k = 11; k < 16; k++) fb[k] = 8'($urandom);
    endtask

    task automatic send_cmd(input logic [7:0] node, input int nb, input int err_mode,
                            input int err_at, input bit set_t, input logic [63:0] t_end,
                            input bit res_with_end);
        cmd_rx_start = 1; cmd_rx_node = node; m_node = int'(node);
        step();
        cmd_rx_start = 0; cmd_rx_node = ~node;
        for (int i = 0; i < nb; i++) begin
            if (err_mode == 2 && err_at == i) begin
                cmd_rx_error = 1; step(); cmd_rx_error = 0;
            end
            s_cmd_valid = 1; s_cmd_pos = 16'(i); s_cmd_data = fb[i];
            step();
            s_cmd_valid = 0; s_cmd_data = 8'($urandom); s_cmd_pos = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) step();
        end
        if (err_mode == 2 && err_at >= nb) begin
            cmd_rx_error = 1; step(); cmd_rx_error = 0;
        end
        if (set_t) current_time = t_end;
        cmd_rx_end = 1;
        cmd_rx_error = (err_mode == 1);
        if (res_with_end) begin
            res_rx_start = 1;
            model_res_start(current_time);
        end
        model_cmd_end(nb, err_mode != 0, current_time);
        step();
        cmd_rx_end = 0; cmd_rx_error = 0; res_rx_start = 0;
        if (res_with_end) begin
            check("coinc_elapsed_raw", 64'(elapsed_time), 64'(m_raw));
            check("coinc_elapsed_ema", 64'(e_elapsed), 64'(m_ema));
        end
    endtask

    task automatic send_res(input int npos, input int err_at, input int reset_at,
                            input bit set_t, input logic [63:0] t);
        int slot;
        if (set_t) current_time = t;
        res_rx_start = 1;
        model_res_start(current_time);
        step();
        res_rx_start = 0;
        check("elapsed_raw", 64'(elapsed_time), 64'(m_raw));
        check("elapsed_ema", 64'(e_elapsed), 64'(m_ema));
        slot = RES_BASE + m_node * EB;
        for (int p = 0; p < npos; p++) begin
            if (p == err_at) begin
                res_rx_error = 1; m_supp = 1;
            end
            s_res_valid = 1; s_res_pos = 16'(p);
            if (!m_supp && p >= slot && p < slot + EB)
                res_q.push_back(8'(m_raw >> (8 * (p - slot))));
            step();
            s_res_valid = 0; res_rx_error = 0; s_res_pos = 16'($urandom_range(0, 60));
            if (p == reset_at) begin
                apply_reset("mid_ins");
                return;
            end
            if ($urandom_range(0, 4) == 0) step();
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_stat_correct"}, 64'(stat_correct_count), 64'(m_corr));
        check({tag, "_stat_error"}, 64'(stat_error_count), 64'(m_err));
        check({tag, "_state_idle"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        #3;
        apply_reset("por");

        // Hard time set, node 2.
        build_frame(8'h03, 64'h0000_0001_0000_0000, 16'h0010);
        send_cmd(8'd2, 11, 0, 0, 0, 64'd0, 0);
        check("t1_valid", 64'(correct_valid), 64'd1);
        check("t1_override", 64'(correct_override), 64'd1);
        check("t1_time", correct_time, 64'h0000_0001_0000_0010);
        check("t1_stat_correct", 64'(stat_correct_count), 64'd1);

        // Truncated adjust frame.
        build_frame(8'h01, {$urandom, $urandom}, 16'($urandom));
        send_cmd(8'd2, 6, 0, 0, 0, 64'd0, 0);
        check("t2_no_valid", 64'(correct_valid), 64'd0);
        check("t2_stat_error", 64'(stat_error_count), 64'd1);
        check("t2_state", 64'(dbg_state), 64'(ST_IDLE));

        // Unknown code, then error coincident with end.
        build_frame(8'h05, {$urandom, $urandom}, 16'($urandom));
        send_cmd(8'd2, 11, 0, 0, 0, 64'd0, 0);
        check("t5a_no_valid", 64'(correct_valid), 64'd0);
        build_frame(8'h01, {$urandom, $urandom}, 16'($urandom));
        send_cmd(8'd2, 11, 1, 0, 0, 64'd0, 0);
        check("t5b_no_valid", 64'(correct_valid), 64'd0);
        check("t5_stat_error", 64'(stat_error_count), 64'd3);
        check("t5_stat_correct", 64'(stat_correct_count), 64'd1);

        // Round trip across a 32-bit wrap, node 3 slot at 21..24.
        build_frame(8'h01, {$urandom, $urandom}, 16'($urandom));
        send_cmd(8'd3, 11, 0, 0, 1, 64'h0000_0000_FFFF_FFF0, 0);
        repeat (3) step();
        send_res(30, -1, -1, 1, 64'h0000_0001_0000_0010);
        check("t3_elapsed", 64'(elapsed_time), 64'h20);
        repeat (2) step();

        // Reset in the middle of command reception.
        cmd_rx_start = 1; cmd_rx_node = 8'd5; step(); cmd_rx_start = 0;
        for (int i = 0; i < 3; i++) begin
            s_cmd_valid = 1; s_cmd_pos = 16'(i); s_cmd_data = 8'h03; step();
        end
        s_cmd_valid = 0;
        apply_reset("mid_recv");

        // Smoothing: samples 100 then 200.
        build_frame(8'h03, {$urandom, $urandom}, 16'($urandom));
        send_cmd(8'd1, 11, 0, 0, 1, 64'd1000, 0);
        send_res(0, -1, -1, 1, 64'd1100);
        check("t4_raw_100", 64'(elapsed_time), 64'd100);
        check("t4_ema_100", 64'(e_elapsed), 64'd100);
        build_frame(8'h01, {$urandom, $urandom}, 16'($urandom));
        send_cmd(8'd1, 11, 0, 0, 1, 64'd5000, 0);
        send_res(0, -1, -1, 1, 64'd5200);
        check("t4_raw_200", 64'(elapsed_time), 64'd200);
        check("t4_ema_125", 64'(e_elapsed), 64'd125);
        check("t4_stat_correct", 64'(stat_correct_count), 64'd2);

        // Response start coincident with command end.
        build_frame(8'h01, {$urandom, $urandom}, 16'($urandom));
        send_cmd(8'd4, 11, 0, 0, 1, 64'd9000, 0);
        build_frame(8'h03, {$urandom, $urandom}, 16'($urandom));
        send_cmd(8'd4, 11, 0, 0, 1, 64'd9050, 1);
        check("coinc_raw_50", 64'(elapsed_time), 64'd50);
        send_res(32, -1, -1, 1, 64'd9080);
        check("coinc_raw_30", 64'(elapsed_time), 64'd30);

        // Reset in the middle of slot insertion (node 1, slot 13..16).
        build_frame(8'h03, {$urandom, $urandom}, 16'($urandom));
        send_cmd(8'd1, 11, 0, 0, 0, 64'd0, 0);
        send_res(20, -1, 14, 0, 64'd0);
        build_frame(8'h01, {$urandom, $urandom}, 16'($urandom));
        send_cmd(8'd2, 11, 0, 0, 0, 64'd0, 0);
        check("post_reset_valid", 64'(correct_valid), 64'd1);
        check("post_reset_stat", 64'(stat_correct_count), 64'd1);

        // Randomised frames and responses.
        for (int it = 0; it < 40; it++) begin
            int r, nb, em, err_at, rerr;
            logic [7:0] code;
            r = $urandom_range(0, 9);
            code = (r < 4) ? 8'h03 : (r < 8) ? 8'h01 : 8'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : NEED;
            r = $urandom_range(0, 9);
            em = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            err_at = $urandom_range(0, nb);
            build_frame(code, {$urandom, $urandom}, 16'($urandom));
            if ($urandom_range(0, 2) == 0) current_time = current_time + {$urandom, $urandom};
            send_cmd(8'($urandom_range(0, 7)), nb, em, err_at, 0, 64'd0, $urandom_range(0, 5) == 0);
            check_stats("rnd");
            repeat ($urandom_range(0, 5)) step();
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 2) == 0) current_time = current_time + 64'($urandom);
                rerr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 39)) : -1;
                send_res(40, rerr, -1, 0, 64'd0);
            end
        end

        repeat (3) step();
        check("corr_q_drained", 64'(corr_q.size()), 64'd0);
        check("res_q_drained", 64'(res_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
